prog_loader: RTL
================

Name: prog_loader

Overview:
Writable instruction store for the 4-bit CPU. It replaces the hard-coded program ROM as the other end of the fetch interface: a host writes a 16-byte program through a valid/ready byte stream, the block verifies a checksum, and the CPU then fetches {op, im} from it by PC. While loading, or after a failed load, it holds the CPU in reset so the core never executes a partial image.

Parameters:
DEPTH, 16, number of program words (one per PC value)
ADDR_W, 4, PC/address width; DEPTH = 2**ADDR_W
DATA_W, 8, instruction width, {op[7:4], im[3:0]}

Ports:
clk  in  1  system clock (same clock as the CPU core)
rst  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse: begin (or restart) a program load
in_data  in  8  program byte from host
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts a byte this cycle
pc  in  4  CPU fetch address
op  out  4  fetched opcode nibble
im  out  4  fetched immediate nibble
cpu_hold  out  1  drives the CPU's rst; high means the core is held
load_ok  out  1  last load passed its checksum; program is running
load_err  out  1  last load failed its checksum

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset state:
  - state = IDLE; addr = 0; sum = 0.
  - All 16 RAM words = 8'h00.
  - in_ready = 0, cpu_hold = 1, load_ok = 0, load_err = 0.
- States:
  - IDLE: no program. cpu_hold = 1. load_start -> LOAD.
  - LOAD: in_ready = 1. Each accepted byte (in_valid & in_ready) is written to RAM[addr]; addr += 1; sum += byte (mod 256). Accepting the byte at addr = 15 -> CKSUM.
  - CKSUM: in_ready = 1. The accepted byte is compared with sum. Equal -> RUN. Not equal -> ERROR.
  - RUN: cpu_hold = 0, load_ok = 1, in_ready = 0.
  - ERROR: cpu_hold = 1, load_err = 1, in_ready = 0.
- load_start in any state: next cycle is LOAD with addr = 0, sum = 0, load_ok = 0, load_err = 0, cpu_hold = 1.
  - If load_start and an accepted byte occur in the same cycle, load_start wins and the byte is dropped (not written, not summed).
  - RAM is not cleared on restart; words are overwritten as the new load proceeds.
- Entering LOAD: cpu_hold rises the cycle after load_start is sampled, so the CPU sees a synchronous reset from then on.
- Leaving hold: cpu_hold falls the cycle after the matching checksum byte is accepted. The CPU then starts at PC 0.
- Fetch port: {op, im} = RAM[pc], combinational, zero latency.
  - While state != RUN, {op, im} is forced to 8'h00 (ADD A,0; harmless while the core is held).
- Write/read ordering: a write and a fetch never overlap, because the CPU is held during LOAD.
- in_valid while in_ready = 0: the byte is ignored. The host must keep it until accepted.
- Width rules:
  - sum is 8 bits and wraps modulo 256.
  - addr is 4 bits. It cannot wrap inside LOAD, because the state leaves LOAD at 15.
- Mid-load rst: returns to IDLE, clears RAM, and keeps the CPU held.

Decomposition:
- Package prog_loader_pkg:
  - state enum {IDLE, LOAD, CKSUM, RUN, ERROR}
  - DEPTH/ADDR_W/DATA_W constants
  - NOP_WORD = 8'h00
- Sub-module prog_ram: 16x8 array with synchronous write, asynchronous read, and synchronous clear on rst.
- The FSM, address counter and checksum accumulator live in prog_loader.

Test Plan:
- Load the timer program: load_start, then B0 B4 01 E0 B8 F5 followed by ten 00 bytes, then checksum F2. Required: load_ok = 1, cpu_hold = 0 one cycle after the F2 byte. pc = 3 gives op = E, im = 0. pc = 5 gives op = F, im = 5.
- Same 16 bytes with checksum F3. Required: load_err = 1, cpu_hold stays 1, {op, im} = 00 for every pc, in_ready = 0.
- Backpressure: in_valid toggled 0/1 every cycle during LOAD. Required: only valid cycles are written, 16 writes total, and the final state matches the first scenario.
- load_start pulse after the 7th byte, then a full reload of 16 x 8'h11 with checksum 10. Required: RUN, and every pc reads op = 1, im = 1.
- rst asserted after the 5th byte. Required: the next cycle shows IDLE with cpu_hold = 1, load_ok = 0, in_ready = 0, and RAM all zero (checked after a subsequent reload with a wrong checksum, which leaves the contents readable via hierarchical peek).
- load_start coincident with an accepted byte while in LOAD at addr = 9. Required: the byte is not written, and addr = 0 and sum = 0 next cycle.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared sizes, fetch NOP word and loader FSM states
package prog_loader_pkg;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] NOP_WORD = 8'h00;
  typedef enum logic [2:0] {IDLE, LOAD, CKSUM, RUN, ERROR} state_e;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: 16x8 program store; ports clk/rst (sync clear), we/waddr/wdata write, raddr/rdata async read
module prog_ram
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: checksummed writable instruction store; host byte stream in (load_start/in_*), fetch {op,im} by pc, cpu_hold/load_ok/load_err status
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [3:0]        op,
  output logic [3:0]        im,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] rdata;
  logic              acc, we;
  assign in_ready = (state_q == LOAD) || (state_q == CKSUM);
  assign cpu_hold = state_q != RUN;
  assign load_ok  = state_q == RUN;
  assign load_err = state_q == ERROR;
  assign acc      = in_valid && in_ready;
  assign we       = acc && (state_q == LOAD) && !load_start;
  assign {op, im} = (state_q == RUN) ? rdata : NOP_WORD;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    if (load_start) begin
      state_d = LOAD;
      addr_d  = '0;
      sum_d   = '0;
    end else if (we) begin
      addr_d  = addr_q + 1'b1;
      sum_d   = sum_q + in_data;
      state_d = (addr_q == ADDR_W'(DEPTH - 1)) ? CKSUM : LOAD;
    end else if (acc && state_q == CKSUM) begin
      state_d = (in_data == sum_q) ? RUN : ERROR;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
    end
  end
  prog_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (addr_q),
    .wdata (in_data),
    .raddr (pc),
    .rdata (rdata)
  );
endmodule
